// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
// Shared definitions for the multiply/divide unit: R-type funct codes of the
// HI/LO group and the controller state encoding.
package mips_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_muldiv_unit_shift_core.sv
// muldiv_shift_core
// Iteration datapath shared by multiply and divide: a DATA_W-bit accumulator,
// a DATA_W-bit shift register, a held operand and an iteration counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture operands, clear accumulator and counter
//   step       : perform one iteration (one product / quotient bit)
//   div_mode   : 1 = restoring divide, 0 = shift-add multiply
//   op_a, op_b : unsigned magnitudes (multiplicand/multiplier or dividend/divisor)
//   last       : current step is the final (DATA_W-th) iteration
//   hi, lo     : multiply: product high/low; divide: remainder/quotient
module muldiv_shift_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              last,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] opnd;
    logic [CNT_W-1:0]  count;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;

    always_comb begin
        mul_sum   = sreg[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
        div_shift = {acc, sreg[DATA_W-1]};
        // Remainder stays below the divisor, so bit DATA_W is a clean borrow.
        div_diff  = div_shift - {1'b0, opnd};
    end

    assign last = (count == CNT_W'(DATA_W - 1));
    assign hi   = acc;
    assign lo   = sreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            sreg  <= '0;
            opnd  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            count <= '0;
            sreg  <= div_mode ? op_a : op_b;
            opnd  <= div_mode ? op_b : op_a;
        end else if (step) begin
            count <= count + 1'b1;
            if (div_mode) begin
                if (!div_diff[DATA_W]) begin
                    acc  <= div_diff[DATA_W-1:0];
                    sreg <= {sreg[DATA_W-2:0], 1'b1};
                end else begin
                    acc  <= div_shift[DATA_W-1:0];
                    sreg <= {sreg[DATA_W-2:0], 1'b0};
                end
            end else begin
                acc  <= mul_sum[DATA_W:1];
                sreg <= {mul_sum[0], sreg[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU (DATA_W+2 cycle latency, Start/Busy/Done
// handshake) and MTHI/MTLO (single edge). MFHI/MFLO read Hi/Lo directly.
// Build option: MULDIV_SIGNED_EN -- when defined MULT/DIV are signed; when
// undefined they behave as MULTU/DIVU and no sign logic is built.
//   clk, reset : clock, synchronous active-high reset
//   Start      : request, sampled only in IDLE
//   Funct      : operation select, sampled with Start
//   SrcA, SrcB : multiplicand/dividend (or MTHI/MTLO data), multiplier/divisor
//   Busy       : operation in flight
//   Done       : one-cycle completion pulse
//   DivByZero  : with Done, divisor was zero
//   Hi, Lo     : HI and LO registers
module alu_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [DATA_W-1:0]  SrcA,
    input  logic [DATA_W-1:0]  SrcB,
    output logic               Busy,
    output logic               Done,
    output logic               DivByZero,
    output logic [DATA_W-1:0]  Hi,
    output logic [DATA_W-1:0]  Lo
);

    state_t state, state_next;

    logic              is_mul, is_div, is_mthi, is_mtlo;
    logic              core_load, core_step, core_div, core_last;
    logic              div_op, dbz;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] core_hi, core_lo;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    assign is_mul  = (Funct == FUNCT_W'(FUNCT_MULT)) || (Funct == FUNCT_W'(FUNCT_MULTU));
    assign is_div  = (Funct == FUNCT_W'(FUNCT_DIV))  || (Funct == FUNCT_W'(FUNCT_DIVU));
    assign is_mthi = (Funct == FUNCT_W'(FUNCT_MTHI));
    assign is_mtlo = (Funct == FUNCT_W'(FUNCT_MTLO));

`ifdef MULDIV_SIGNED_EN
    logic                sgn_op, neg_a, neg_b;
    logic                neg_res, neg_rem;
    logic [2*DATA_W-1:0] prod_neg;

    assign sgn_op = (Funct == FUNCT_W'(FUNCT_MULT)) || (Funct == FUNCT_W'(FUNCT_DIV));
    assign neg_a  = sgn_op & SrcA[DATA_W-1];
    assign neg_b  = sgn_op & SrcB[DATA_W-1];
    // Most-negative maps to itself, which is its correct unsigned magnitude.
    assign op_a   = neg_a ? -SrcA : SrcA;
    assign op_b   = neg_b ? -SrcB : SrcB;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (core_load) begin
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a & is_div;
        end
    end

    assign prod_neg = -{core_hi, core_lo};

    always_comb begin
        fix_hi = core_hi;
        fix_lo = core_lo;
        if (div_op) begin
            if (neg_res) fix_lo = -core_lo;
            if (neg_rem) fix_hi = -core_hi;
        end else if (neg_res) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end
`else
    assign op_a   = SrcA;
    assign op_b   = SrcB;
    assign fix_hi = core_hi;
    assign fix_lo = core_lo;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        core_div   = div_op;
        case (state)
            ST_IDLE: begin
                core_div = is_div;
                if (Start) begin
                    if (is_mul) begin
                        core_load  = 1'b1;
                        state_next = ST_MUL;
                    end else if (is_div) begin
                        if (SrcB == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            core_load  = 1'b1;
                            state_next = ST_DIV;
                        end
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                core_step = 1'b1;
                if (core_last) state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_op <= 1'b0;
            dbz    <= 1'b0;
        end else if (state == ST_IDLE && Start) begin
            div_op <= is_div;
            dbz    <= is_div && (SrcB == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == ST_FIX) begin
            Hi <= fix_hi;
            Lo <= fix_lo;
        end else if (state == ST_IDLE && Start) begin
            if (is_mthi) Hi <= SrcA;
            if (is_mtlo) Lo <= SrcA;
        end
    end

    assign Busy      = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign Done      = (state == ST_DONE);
    assign DivByZero = (state == ST_DONE) && dbz;

    muldiv_shift_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .step     (core_step),
        .div_mode (core_div),
        .op_a     (op_a),
        .op_b     (op_b),
        .last     (core_last),
        .hi       (core_hi),
        .lo       (core_lo)
    );

endmodule
